// File: rtl/logic_unit_seq.sv
// Bit-sliced bitwise logic unit: processes SLICE bits per cycle
// over latched operands, then publishes the full result on Y.
module logic_unit_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y,
   output logic             ZERO,
   output logic             BUSY,
   output logic             DONE
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_nxt;
   logic [WIDTH-1:0] full;
   logic             last;
   logic             accept;

   always_comb begin
      full = '0;
      case (op_q)
         3'b000:  full = a_q & b_q;
         3'b001:  full = a_q | b_q;
         3'b010:  full = ~(a_q | b_q);
         3'b011:  full = ~a_q;
         3'b100:  full = a_q ^ b_q;
         3'b101:  full = ~(a_q & b_q);
         3'b110:  full = ~(a_q ^ b_q);
         default: full = a_q;
      endcase
   end

   // Only the slice selected by the counter is merged this cycle.
   always_comb begin
      work_nxt = work;
      for (int k = 0; k < N; k++) begin
         if (cnt == CW'(k)) begin
            work_nxt[k*SLICE +: SLICE] = full[k*SLICE +: SLICE];
         end
      end
   end

   assign last   = (cnt == CW'(N - 1));
   assign accept = START && (state != RUN);

   always_comb begin
      state_nxt = state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      unique case (state)
         IDLE: begin
            if (START) state_nxt = RUN;
         end
         RUN: begin
            BUSY = 1'b1;
            if (last) state_nxt = FIN;
         end
         FIN: begin
            DONE      = 1'b1;
            state_nxt = START ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         work  <= '0;
         Y     <= '0;
         ZERO  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= OP;
            cnt  <= '0;
         end
         if (state == RUN) begin
            work <= work_nxt;
            if (last) begin
               Y    <= work_nxt;
               ZERO <= (work_nxt == '0);
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: two instances (32/8 and 16/16)
// driven by directed and random stimulus against a behavioural model.
module tb_logic_unit_seq;

   logic        clk;
   logic        rst_i   [2];
   logic        start_i [2];
   logic [2:0]  op_i    [2];
   logic [31:0] a_i     [2];
   logic [31:0] b_i     [2];

   logic [31:0] y0;
   logic        zero0;
   logic        busy0;
   logic        done0;
   logic [15:0] y1;
   logic        zero1;
   logic        busy1;
   logic        done1;

   logic_unit_seq #(.WIDTH(32), .SLICE(8)) u0 (
      .CLK(clk), .RST(rst_i[0]), .START(start_i[0]),
      .OP(op_i[0]), .A(a_i[0]), .B(b_i[0]),
      .Y(y0), .ZERO(zero0), .BUSY(busy0), .DONE(done0)
   );

   logic_unit_seq #(.WIDTH(16), .SLICE(16)) u1 (
      .CLK(clk), .RST(rst_i[1]), .START(start_i[1]),
      .OP(op_i[1]), .A(a_i[1][15:0]), .B(b_i[1][15:0]),
      .Y(y1), .ZERO(zero1), .BUSY(busy1), .DONE(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      int          issue;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          run_left [2];
   logic [31:0] model_y  [2];
   int          cyc;
   int          tests;
   int          fails;
   bit          go;

   function automatic int nslices(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic logic [31:0] wmask(input int i);
      return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endfunction

   // Reference: bitwise op on whole words; slicing is invisible here.
   function automatic logic [31:0] ref_op(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'd0:    r = a & b;
         3'd1:    r = a | b;
         3'd2:    r = ~(a | b);
         3'd3:    r = ~a;
         3'd4:    r = a ^ b;
         3'd5:    r = ~(a & b);
         3'd6:    r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

   task automatic drive(input int i, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      start_i[i] = st;
      op_i[i]    = op;
      a_i[i]     = a;
      b_i[i]     = b;
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst_i[i]) begin
            if (i == 0) q0.delete(); else q1.delete();
            run_left[i] = 0;
            model_y[i]  = 32'h0;
         end else if (run_left[i] > 0) begin
            run_left[i]--;
         end else if (start_i[i]) begin
            e.y     = ref_op(op_i[i], a_i[i], b_i[i]) & wmask(i);
            e.issue = cyc;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
            run_left[i] = nslices(i);
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      start_i[0] = 1'b0;
      start_i[1] = 1'b0;
      repeat (n) tick();
   endtask

   task automatic check(input int i);
      logic [31:0] y;
      logic        z;
      logic        bz;
      logic        dn;
      bit          hv;
      exp_t        h;
      y  = (i == 0) ? y0 : {16'h0, y1};
      z  = (i == 0) ? zero0 : zero1;
      bz = (i == 0) ? busy0 : busy1;
      dn = (i == 0) ? done0 : done1;
      hv = 0;
      if (i == 0 && q0.size() > 0) begin hv = 1; h = q0[0]; end
      if (i == 1 && q1.size() > 0) begin hv = 1; h = q1[0]; end
      tests++;
      if (bz !== (run_left[i] > 0)) begin
         fails++;
         $display("FAIL busy inst%0d cyc%0d got=%b exp=%b",
                  i, cyc, bz, run_left[i] > 0);
      end
      if (hv && (h.issue + nslices(i) <= cyc)) begin
         tests++;
         if (dn !== 1'b1) begin
            fails++;
            $display("FAIL done_missing inst%0d cyc%0d got=%b exp=1",
                     i, cyc, dn);
         end
         tests++;
         if (y !== h.y || z !== (h.y == 32'h0)) begin
            fails++;
            $display("FAIL result inst%0d cyc%0d got=%h/%b exp=%h/%b",
                     i, cyc, y, z, h.y, h.y == 32'h0);
         end
         model_y[i] = h.y;
         if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end else begin
         tests++;
         if (dn !== 1'b0) begin
            fails++;
            $display("FAIL done_spurious inst%0d cyc%0d got=%b exp=0",
                     i, cyc, dn);
         end
         tests++;
         if (y !== model_y[i] || z !== (model_y[i] == 32'h0)) begin
            fails++;
            $display("FAIL hold inst%0d cyc%0d got=%h/%b exp=%h/%b",
                     i, cyc, y, z, model_y[i], model_y[i] == 32'h0);
         end
      end
   endtask

   always @(negedge clk) begin
      if (go) begin
         for (int i = 0; i < 2; i++) check(i);
      end
   end

   initial begin
      cyc   = 0;
      tests = 0;
      fails = 0;
      go    = 0;
      for (int i = 0; i < 2; i++) begin
         rst_i[i]    = 1'b1;
         run_left[i] = 0;
         model_y[i]  = 32'h0;
         drive(i, 1'b0, 3'd0, 32'h0, 32'h0);
      end
      go = 1;
      tick();
      tick();
      rst_i[0] = 1'b0;
      rst_i[1] = 1'b0;
      idle(2);

      // AND across slices
      drive(0, 1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
      tick();
      idle(6);

      // NOR to all-zero result
      drive(0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0000_0000);
      tick();
      idle(6);

      // operand change and START while running are ignored
      drive(0, 1'b1, 3'b100, 32'hAAAA_AAAA, 32'h5555_5555);
      tick();
      drive(0, 1'b0, 3'b100, 32'hAAAA_AAAA, 32'h5555_5555);
      tick();
      drive(0, 1'b1, 3'b000, 32'h0, 32'h5555_5555);
      tick();
      idle(6);

      // back-to-back: restart during the DONE cycle
      drive(0, 1'b1, 3'b011, 32'h0, 32'h0);
      tick();
      idle(4);
      drive(0, 1'b1, 3'b111, 32'h1234_5678, 32'hDEAD_BEEF);
      tick();
      idle(6);

      // reset during the 2nd busy cycle aborts
      drive(0, 1'b1, 3'b001, 32'h1357_9BDF, 32'h0246_8ACE);
      tick();
      drive(0, 1'b0, 3'b001, 32'h0, 32'h0);
      tick();
      rst_i[0] = 1'b1;
      tick();
      rst_i[0] = 1'b0;
      idle(6);

      // single-slice instance: NAND
      drive(1, 1'b1, 3'b101, 32'h0000_FF00, 32'h0000_0FF0);
      tick();
      idle(3);

      // reset together with START: reset wins
      rst_i[1] = 1'b1;
      drive(1, 1'b1, 3'b111, 32'h0000_ABCD, 32'h0);
      tick();
      rst_i[1] = 1'b0;
      idle(3);

      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            rst_i[i] = ($urandom_range(0, 59) == 0);
            drive(i, ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)), $urandom, $urandom);
         end
         tick();
      end
      rst_i[0] = 1'b0;
      rst_i[1] = 1'b0;
      idle(8);

      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         fails++;
         $display("FAIL drain got=%0d/%0d pending exp=0/0",
                  q0.size(), q1.size());
      end
      go = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/logic_unit_seq.md
LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SLICE, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, with N = WIDTH/SLICE.
REQ-003 CLK  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  request to begin an operation, sampled at each rising CLK edge.
REQ-006 OP  input  3  operation select, sampled with START.
REQ-007 A  input  WIDTH  first operand, sampled with START.
REQ-008 B  input  WIDTH  second operand, sampled with START.
REQ-009 Y  output  WIDTH  registered result of the last completed operation.
REQ-010 ZERO  output  1  registered flag, 1 when Y is all zeros.
REQ-011 BUSY  output  1  high while slices are being processed.
REQ-012 DONE  output  1  one-cycle completion pulse.

Function
REQ-013 The OP encoding SHALL be: 000 AND, 001 OR, 010 NOR, 011 NOT A, 100 XOR, 101 NAND, 110 XNOR, 111 pass A; all ops are bitwise, and B SHALL be ignored for 011 and 111.
REQ-014 The block SHALL be an FSM with three states, IDLE, RUN and FIN, using a slice counter of width ceil(log2(N)) (minimum 1).
REQ-015 In IDLE or FIN, START=1 at an edge SHALL latch A, B and OP into internal registers, clear the counter to 0 and enter RUN.
REQ-016 In RUN, each edge SHALL compute bits [k*SLICE +: SLICE] of the latched operands for counter value k, store them in a working result register and increment k.
REQ-017 At the edge that processes slice N-1, the FSM SHALL enter FIN, load Y with the full working result and load ZERO with (result == 0).
REQ-018 Latency: with START sampled at edge e0, BUSY SHALL be high during the cycles after e0 through eN-1, and DONE SHALL be high for exactly the one cycle after eN.
REQ-019 In FIN without START, the FSM SHALL return to IDLE at the next edge.
REQ-020 In FIN with START, a new operation SHALL begin at that edge (back-to-back), with DONE low in the next cycle.
REQ-021 START in RUN SHALL be ignored, with no queuing.
REQ-022 Changes on A, B or OP after the latching edge SHALL have no effect on the operation in progress.
REQ-023 Y and ZERO SHALL hold their previous values throughout RUN and SHALL update only at the completion edge.
REQ-024 When SLICE == WIDTH (N = 1), RUN SHALL last exactly one cycle and the counter SHALL stay at 0.
REQ-025 BUSY SHALL be 1 if and only if state = RUN, and DONE SHALL be 1 if and only if state = FIN; both SHALL be decoded from registered state only.

Reset
REQ-026 RST=1 at an edge SHALL force: state IDLE, counter 0, Y=0, ZERO=1, BUSY=0, DONE=0, and internal operand and working registers 0.
REQ-027 RST SHALL take priority over START in the same cycle.
REQ-028 RST asserted during RUN SHALL abort the operation; no DONE pulse SHALL follow and Y SHALL read 0.

Verification
REQ-029 WIDTH=32, SLICE=8: A=F0F0_1234, B=0FF0_FFFF, OP=000, START one cycle -> BUSY high 4 cycles, then DONE high 1 cycle; Y=00F0_1234, ZERO=0.
REQ-030 A=FFFF_FFFF, B=0000_0000, OP=010 -> Y=0000_0000, ZERO=1 at DONE; Y holds its prior value during all 4 BUSY cycles.
REQ-031 Start OP=100 with A=AAAA_AAAA, B=5555_5555; in the 2nd BUSY cycle change A to 0 and pulse START with OP=000 -> both ignored; Y=FFFF_FFFF, one DONE only.
REQ-032 Back-to-back: OP=011, A=0 completes (Y=FFFF_FFFF); START held during the DONE cycle with OP=111, A=1234_5678 -> BUSY the next cycle; after 4 more cycles Y=1234_5678 and exactly two DONE pulses in total.
REQ-033 Assert RST in the 2nd BUSY cycle of any operation -> next cycle BUSY=0, DONE=0, Y=0, ZERO=1, and no DONE thereafter until a new START.
REQ-034 WIDTH=16, SLICE=16: OP=101, A=FF00, B=0FF0, START -> BUSY 1 cycle, then DONE; Y=F0FF, ZERO=0.
